// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   - fetch_state_e : fetch FSM states (BOOT, FETCH, HOLD)
//   - XLEN / ILEN   : address and instruction widths
//   - INSTR_BYTES   : PC increment per fetched word
//   - DEF_RESET_PC  : default first fetch address after reset
package fetch_pkg;

  localparam int XLEN        = 64;
  localparam int ILEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] DEF_RESET_PC = 64'h0;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  // Redirect targets must be word aligned; anything else is rejected.
  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, fetches words from instruction
// memory over a req/ready handshake and holds the result in a one-entry
// output buffer whose PC feeds the branch adder.
//
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   branch_taken      : redirect strobe from the branch adder
//   branch_target     : redirect address (must be word aligned)
//   imem_req/addr     : fetch request and address (addr = pc)
//   imem_ready/rdata  : memory accept and returned instruction word
//   instr_valid/ready : output buffer handshake
//   instr, instr_pc   : buffered instruction and its PC
//   misalign_err      : one-cycle pulse after a rejected (misaligned) redirect
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic        misalign_err
);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            redir_pend, redir_pend_nxt;
  logic [XLEN-1:0] redir_addr, redir_addr_nxt;
  logic [ILEN-1:0] instr_q, instr_nxt;
  logic [XLEN-1:0] instr_pc_q, instr_pc_nxt;
  logic            misalign_q;

  // A misaligned redirect is treated exactly as if no redirect arrived;
  // its only visible effect is the error pulse.
  logic br_ok;
  assign br_ok = branch_taken & is_word_aligned(branch_target);

  // Outputs are decoded from state or taken straight from registers, so
  // branch_taken / instr_ready never reach an output combinationally.
  assign imem_req     = (state == FETCH);
  assign imem_addr    = pc;
  assign instr_valid  = (state == HOLD);
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign misalign_err = misalign_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      redir_pend <= 1'b0;
      redir_addr <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      redir_pend <= redir_pend_nxt;
      redir_addr <= redir_addr_nxt;
      instr_q    <= instr_nxt;
      instr_pc_q <= instr_pc_nxt;
      misalign_q <= branch_taken & ~is_word_aligned(branch_target);
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    redir_pend_nxt = redir_pend;
    redir_addr_nxt = redir_addr;
    instr_nxt      = instr_q;
    instr_pc_nxt   = instr_pc_q;

    unique case (state)
      BOOT: begin
        // A redirect during boot steers the very first fetch.
        if (br_ok) pc_nxt = branch_target;
        state_nxt = FETCH;
      end

      FETCH: begin
        if (imem_ready) begin
          if (br_ok || redir_pend) begin
            // The returning word belongs to the wrong path: drop it and
            // re-aim the PC. A same-cycle redirect is newer than the
            // pending one, so it wins.
            pc_nxt         = br_ok ? branch_target : redir_addr;
            redir_pend_nxt = 1'b0;
          end else begin
            instr_nxt    = imem_rdata;
            instr_pc_nxt = pc;
            // Unsigned increment; wraps modulo 2^64.
            pc_nxt       = pc + XLEN'(INSTR_BYTES);
            state_nxt    = HOLD;
          end
        end else if (br_ok) begin
          // The request in flight must keep its address until accepted,
          // so the redirect is parked until the response arrives.
          redir_pend_nxt = 1'b1;
          redir_addr_nxt = branch_target;
        end
      end

      HOLD: begin
        // instr_ready completes the transfer; a redirect without it flushes
        // the buffer. Either way fetching resumes, at the target if one came.
        if (instr_ready || br_ok) begin
          state_nxt = FETCH;
          if (br_ok) pc_nxt = branch_target;
        end
      end

      default: state_nxt = BOOT;
    endcase
  end

endmodule
